// File: rtl/inta_cycle_master.sv
// Interrupt-acknowledge bus master: answers the PIC's INT line with a locked
// two-pulse INTA sequence, captures the vector and offers it to the core.
module inta_cycle_master #(
  parameter int PULSE_W = 2,
  parameter int GAP_W   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       INT,
  input  logic       IF_EN,
  input  logic [7:0] DATA_IN,
  output logic       INTA,
  output logic       LOCK,
  output logic [7:0] VECTOR,
  output logic       VEC_VALID,
  input  logic       VEC_READY,
  output logic       BUSY
);

  localparam int MAX_W = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
  localparam int CW    = $clog2(MAX_W) + 1;

  localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_W - 1);
  localparam logic [CW-1:0] GAP_LOAD   = CW'(GAP_W - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  typedef enum logic [2:0] {
    IDLE,
    ACK1,
    GAP,
    ACK2,
    HOLD
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          capture;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (INT && IF_EN) begin
          state_nxt = ACK1;
          cnt_nxt   = PULSE_LOAD;
        end
      end
      ACK1: begin
        if (cnt == '0) begin
          state_nxt = GAP;
          cnt_nxt   = GAP_LOAD;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      GAP: begin
        if (cnt == '0) begin
          state_nxt = ACK2;
          cnt_nxt   = PULSE_LOAD;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      ACK2: begin
        // The PIC drives the vector during the second pulse; take it as the pulse ends.
        if (cnt == '0) begin
          state_nxt = HOLD;
          cnt_nxt   = '0;
          capture   = 1'b1;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      HOLD: begin
        if (VEC_READY) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they are true flops aligned with the state.
  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      INTA      <= 1'b1;
      LOCK      <= 1'b0;
      VECTOR    <= 8'h00;
      VEC_VALID <= 1'b0;
      BUSY      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      INTA      <= !((state_nxt == ACK1) || (state_nxt == ACK2));
      LOCK      <= (state_nxt == ACK1) || (state_nxt == GAP) || (state_nxt == ACK2);
      VEC_VALID <= (state_nxt == HOLD);
      BUSY      <= (state_nxt != IDLE);
      if (capture) begin
        VECTOR <= DATA_IN;
      end
    end
  end

endmodule
